// File: rtl/enigma_regbank_pkg.sv
// enigma_regbank_pkg
// Register offsets, decoded register selector, STATUS/CTRL/ROTOR field
// positions, the letter ceiling and default FIFO depth for the Enigma
// register bank slice.
package enigma_regbank_pkg;

  // Byte offsets of the register map
  localparam logic [4:0] OFF_CTRL      = 5'h00;
  localparam logic [4:0] OFF_ROTOR_SEL = 5'h04;
  localparam logic [4:0] OFF_ROTOR_POS = 5'h08;
  localparam logic [4:0] OFF_STATUS    = 5'h0C;
  localparam logic [4:0] OFF_DATA_IN   = 5'h10;
  localparam logic [4:0] OFF_IRQ_MASK  = 5'h14;

  // Word index (byte offset [4:2]) of each register slot
  typedef enum logic [2:0] {
    REG_CTRL      = 3'd0,
    REG_ROTOR_SEL = 3'd1,
    REG_ROTOR_POS = 3'd2,
    REG_STATUS    = 3'd3,
    REG_DATA_IN   = 3'd4,
    REG_IRQ_MASK  = 3'd5,
    REG_RSVD6     = 3'd6,
    REG_RSVD7     = 3'd7
  } regSel_e;

  // CTRL bits
  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_CLR   = 1;

  // STATUS fields
  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_DONE    = 1;
  localparam int unsigned ST_FULL    = 2;
  localparam int unsigned ST_EMPTY   = 3;
  localparam int unsigned ST_OVF     = 4;
  localparam int unsigned ST_LVL_LSB = 8;
  localparam int unsigned ST_LVL_W   = 3;

  // IRQ_MASK bits
  localparam int unsigned IRQ_DONE = 0;
  localparam int unsigned IRQ_OVF  = 1;

  // ROTOR_SEL: [2:0] left, [6:4] middle, [10:8] right, [13:12] reflector
  localparam logic [13:0] ROTOR_SEL_MASK = 14'h3777;
  // ROTOR_POS: [4:0], [12:8], [20:16]
  localparam logic [20:0] ROTOR_POS_MASK = 21'h1F1F1F;

  // Letters are 0 ('A') to 25 ('Z')
  localparam int unsigned LETTER_W   = 5;
  localparam logic [4:0]  LETTER_MAX = 5'd25;

  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  // Map a byte address onto its register slot
  function automatic regSel_e decodeReg(input logic [4:0] byteAddr);
    return regSel_e'(byteAddr[4:2]);
  endfunction

endpackage

// File: rtl/enigma_char_fifo.sv
// enigma_char_fifo
// Small letter FIFO feeding the cipher engine.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   push_i, pushData_i   push request and letter
//   pop_i                pop request (ignored while empty)
//   clear_i              empty the FIFO; beats push and pop
//   headData_o           letter at the head
//   full_o, empty_o      occupancy flags
//   level_o              number of stored letters
module enigma_char_fifo
  import enigma_regbank_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic [LETTER_W-1:0] pushData_i,
  input  logic                pop_i,
  input  logic                clear_i,
  output logic [LETTER_W-1:0] headData_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [LVL_W-1:0]    level_o
);

  logic [LETTER_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    rdPtr_q;
  logic [PTR_W-1:0]    wrPtr_q;
  logic [LVL_W-1:0]    level_q;
  logic                popOk;
  logic                pushOk;

  assign full_o     = (level_q == LVL_W'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign headData_o = mem_q[rdPtr_q];

  // A push into a full FIFO is still accepted when the head leaves the
  // same cycle, so the level does not change.
  assign popOk  = pop_i & ~empty_o;
  assign pushOk = push_i & (~full_o | popOk);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (popOk) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      if (pushOk) begin
        mem_q[wrPtr_q] <= pushData_i;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      case ({pushOk, popOk})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/enigma_regbank.sv
// enigma_regbank
// Register bank between a forwarded APB-style access port and the Enigma
// cipher engine: rotor configuration, start/clear control, sticky status,
// and a letter FIFO drained by the engine.
// Ports:
//   apb_clock, apb_aresn        clock, async active-low reset
//   fwrite/fenable/faddr/fwdata forwarded access
//   frdata, fslverror           combinational read data and error
//   eng_start                   one-cycle start pulse
//   cfg_rotor_sel/cfg_rotor_pos rotor configuration
//   eng_busy, eng_done          engine state and completion pulse
//   eng_char_valid/_char/_ready letter stream to the engine
//   irq                         level interrupt
// Build option: define ENIGMA_REGBANK_IRQ_EN to add IRQ_MASK at 0x14 and a
// live irq; otherwise irq is 0 and 0x14 is unmapped.
module enigma_regbank
  import enigma_regbank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  apb_clock,
  input  logic                  apb_aresn,
  input  logic                  fwrite,
  input  logic                  fenable,
  input  logic [ADDR_WIDTH-1:0] faddr,
  input  logic [DATA_WIDTH-1:0] fwdata,
  output logic [DATA_WIDTH-1:0] frdata,
  output logic                  fslverror,
  output logic                  eng_start,
  output logic [13:0]           cfg_rotor_sel,
  output logic [20:0]           cfg_rotor_pos,
  input  logic                  eng_busy,
  input  logic                  eng_done,
  output logic                  eng_char_valid,
  output logic [4:0]            eng_char,
  input  logic                  eng_char_ready,
  output logic                  irq
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [13:0]      rotorSel_q;
  logic [20:0]      rotorPos_q;
  logic             done_q;
  logic             overflow_q;
  logic             startPulse_q;
  logic             phaseArmed_q;

  regSel_e          regSel;
  logic [31:0]      wdata32;
  logic [31:0]      readWord;
  logic [31:0]      statusWord;
  logic [31:0]      levelWide;
  logic [4:0]       letter;
  logic             letterOk;
  logic             mapped;
  logic             busErr;
  logic             writeCommit;
  logic             popNow;
  logic             pushReq;
  logic             clearReq;
  logic             startReq;
  logic             overflowSet;
  logic             statusW1c;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [LVL_W-1:0] fifoLevel;
  logic             unusedBits;

  assign regSel   = decodeReg(faddr[4:0]);
  assign wdata32  = 32'(fwdata);
  assign letter   = wdata32[4:0];
  assign letterOk = (letter <= LETTER_MAX);
  assign popNow   = eng_char_valid & eng_char_ready;

  // Only the first enable cycle after a setup cycle commits. The arm flag
  // resets to 0, so an access cut by reset never commits afterwards.
  assign writeCommit = fenable & fwrite & phaseArmed_q;

  // Address decode and access-error classification
  always_comb begin
    mapped = 1'b0;
    busErr = 1'b0;
    case (regSel)
      REG_CTRL, REG_ROTOR_SEL, REG_ROTOR_POS, REG_STATUS, REG_DATA_IN:
        mapped = 1'b1;
`ifdef ENIGMA_REGBANK_IRQ_EN
      REG_IRQ_MASK: mapped = 1'b1;
`endif
      default: mapped = 1'b0;
    endcase
    if (!mapped) begin
      busErr = 1'b1;
    end else if (fwrite) begin
      case (regSel)
        REG_ROTOR_SEL, REG_ROTOR_POS: busErr = eng_busy;
        REG_CTRL:    busErr = eng_busy & wdata32[CTRL_START];
        REG_DATA_IN: busErr = ~letterOk | (fifoFull & ~popNow);
        default:     busErr = 1'b0;
      endcase
    end
  end

  assign fslverror = fenable & busErr;

  // A rejected CTRL write (START while busy) is dropped entirely.
  assign clearReq    = writeCommit & (regSel == REG_CTRL) & ~busErr & wdata32[CTRL_CLR];
  assign startReq    = writeCommit & (regSel == REG_CTRL) & ~busErr & wdata32[CTRL_START];
  assign pushReq     = writeCommit & (regSel == REG_DATA_IN) & letterOk & ~clearReq;
  assign overflowSet = pushReq & fifoFull & ~popNow;
  assign statusW1c   = writeCommit & (regSel == REG_STATUS);

  // Configuration registers, start pulse and sticky flags; a set from the
  // engine or FIFO beats a simultaneous write-1-to-clear.
  always_ff @(posedge apb_clock or negedge apb_aresn) begin
    if (!apb_aresn) begin
      rotorSel_q   <= '0;
      rotorPos_q   <= '0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      startPulse_q <= 1'b0;
      phaseArmed_q <= 1'b0;
    end else begin
      phaseArmed_q <= ~fenable;
      startPulse_q <= startReq;
      if (writeCommit && regSel == REG_ROTOR_SEL && !busErr) begin
        rotorSel_q <= wdata32[13:0] & ROTOR_SEL_MASK;
      end
      if (writeCommit && regSel == REG_ROTOR_POS && !busErr) begin
        rotorPos_q <= wdata32[20:0] & ROTOR_POS_MASK;
      end
      if (eng_done) begin
        done_q <= 1'b1;
      end else if (statusW1c && wdata32[ST_DONE]) begin
        done_q <= 1'b0;
      end
      if (overflowSet) begin
        overflow_q <= 1'b1;
      end else if (statusW1c && wdata32[ST_OVF]) begin
        overflow_q <= 1'b0;
      end
    end
  end

`ifdef ENIGMA_REGBANK_IRQ_EN
  logic [1:0] irqMask_q;

  always_ff @(posedge apb_clock or negedge apb_aresn) begin
    if (!apb_aresn) begin
      irqMask_q <= '0;
    end else if (writeCommit && regSel == REG_IRQ_MASK) begin
      irqMask_q <= wdata32[1:0];
    end
  end

  assign irq = |(irqMask_q & {overflow_q, done_q});
`else
  assign irq = 1'b0;
`endif

  enigma_char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (apb_clock),
    .rst_ni     (apb_aresn),
    .push_i     (pushReq),
    .pushData_i (letter),
    .pop_i      (popNow),
    .clear_i    (clearReq),
    .headData_o (eng_char),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .level_o    (fifoLevel)
  );

  assign levelWide = 32'(fifoLevel);

  // Read mux; CTRL and DATA_IN always read 0
  always_comb begin
    statusWord                              = '0;
    statusWord[ST_BUSY]                     = eng_busy;
    statusWord[ST_DONE]                     = done_q;
    statusWord[ST_FULL]                     = fifoFull;
    statusWord[ST_EMPTY]                    = fifoEmpty;
    statusWord[ST_OVF]                      = overflow_q;
    statusWord[ST_LVL_LSB +: ST_LVL_W]      = levelWide[ST_LVL_W-1:0];
    readWord = '0;
    case (regSel)
      REG_ROTOR_SEL: readWord = 32'(rotorSel_q);
      REG_ROTOR_POS: readWord = 32'(rotorPos_q);
      REG_STATUS:    readWord = statusWord;
`ifdef ENIGMA_REGBANK_IRQ_EN
      REG_IRQ_MASK:  readWord = 32'(irqMask_q);
`endif
      default:       readWord = '0;
    endcase
  end

  assign frdata = (apb_aresn && fenable && !fwrite) ? DATA_WIDTH'(readWord) : '0;

  assign eng_start      = startPulse_q;
  assign cfg_rotor_sel  = rotorSel_q;
  assign cfg_rotor_pos  = rotorPos_q;
  assign eng_char_valid = ~fifoEmpty;

  // Address byte lanes and upper data bits carry no meaning here
  assign unusedBits = ^{faddr, wdata32};

endmodule

// File: tb/tb_enigma_regbank.sv
// tb_enigma_regbank
// Scoreboard bench for enigma_regbank: stimulus tasks queue the expected
// bus response or engine letter, and a monitor compares them whenever the
// DUT presents an access phase or a letter handshake.
module tb_enigma_regbank;

  logic        apb_clock = 1'b0;
  logic        apb_aresn = 1'b0;
  logic        fwrite = 1'b0;
  logic        fenable = 1'b0;
  logic [4:0]  faddr = '0;
  logic [31:0] fwdata = '0;
  logic [31:0] frdata;
  logic        fslverror;
  logic        eng_start;
  logic [13:0] cfg_rotor_sel;
  logic [20:0] cfg_rotor_pos;
  logic        eng_busy = 1'b0;
  logic        eng_done = 1'b0;
  logic        eng_char_valid;
  logic [4:0]  eng_char;
  logic        eng_char_ready = 1'b0;
  logic        irq;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
  } busExp_t;

  typedef struct {
    string      name;
    logic [4:0] ch;
  } charExp_t;

  busExp_t  busQ[$];
  charExp_t charQ[$];
  busExp_t  curBus;
  charExp_t curChar;
  int       checks = 0;
  int       errors = 0;
  int       startCount = 0;

  enigma_regbank #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .FIFO_DEPTH (4)
  ) dut (
    .apb_clock      (apb_clock),
    .apb_aresn      (apb_aresn),
    .fwrite         (fwrite),
    .fenable        (fenable),
    .faddr          (faddr),
    .fwdata         (fwdata),
    .frdata         (frdata),
    .fslverror      (fslverror),
    .eng_start      (eng_start),
    .cfg_rotor_sel  (cfg_rotor_sel),
    .cfg_rotor_pos  (cfg_rotor_pos),
    .eng_busy       (eng_busy),
    .eng_done       (eng_done),
    .eng_char_valid (eng_char_valid),
    .eng_char       (eng_char),
    .eng_char_ready (eng_char_ready),
    .irq            (irq)
  );

  always #5 apb_clock = ~apb_clock;

  // Single comparison point; every check goes through here
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge
  always @(negedge apb_clock) begin
    if (eng_start) startCount++;
    if (fenable) begin
      if (busQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL bus_unexpected: access at addr 0x%0h with no expectation", faddr);
      end else begin
        curBus = busQ.pop_front();
        checkOutput({curBus.name, "_rdata"}, frdata, curBus.data);
        checkOutput({curBus.name, "_err"}, {31'b0, fslverror}, {31'b0, curBus.err});
      end
    end
    if (eng_char_valid && eng_char_ready) begin
      if (charQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL char_unexpected: popped %0d with no expectation", eng_char);
      end else begin
        curChar = charQ.pop_front();
        checkOutput(curChar.name, {27'b0, eng_char}, {27'b0, curChar.ch});
      end
    end
  end

  // One setup cycle plus one enable cycle; optional engine pop / done
  // pulse aligned with the enable cycle
  task automatic applyStimulus(input string name, input bit wr, input logic [4:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expData,
                               input bit expErr, input bit withPop, input bit withDone);
    busQ.push_back('{name, expData, expErr});
    @(posedge apb_clock); #1;
    fwrite  = wr;
    faddr   = addr;
    fwdata  = wdata;
    fenable = 1'b1;
    if (withPop)  eng_char_ready = 1'b1;
    if (withDone) eng_done = 1'b1;
    @(posedge apb_clock); #1;
    fenable        = 1'b0;
    fwrite         = 1'b0;
    fwdata         = '0;
    eng_char_ready = 1'b0;
    eng_done       = 1'b0;
  endtask

  task automatic busWrite(input string name, input logic [4:0] addr,
                          input logic [31:0] wdata, input bit expErr);
    applyStimulus(name, 1'b1, addr, wdata, 32'h0, expErr, 1'b0, 1'b0);
  endtask

  task automatic busRead(input string name, input logic [4:0] addr,
                         input logic [31:0] expData, input bit expErr);
    applyStimulus(name, 1'b0, addr, 32'h0, expData, expErr, 1'b0, 1'b0);
  endtask

  // Engine-side pop with a bounded wait for valid
  task automatic popChar(input string name, input logic [4:0] expCh);
    int n = 0;
    charQ.push_back('{name, expCh});
    while (!eng_char_valid && n < 20) begin
      @(posedge apb_clock); #1;
      n++;
    end
    if (!eng_char_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: eng_char_valid stayed 0, expected letter %0d", name, expCh);
      charQ.delete(charQ.size() - 1);
    end else begin
      eng_char_ready = 1'b1;
      @(posedge apb_clock); #1;
      eng_char_ready = 1'b0;
    end
  endtask

  task automatic pulseDone();
    @(posedge apb_clock); #1;
    eng_done = 1'b1;
    @(posedge apb_clock); #1;
    eng_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge apb_clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    #3;
    checkOutput("rst_eng_start", {31'b0, eng_start}, 32'h0);
    checkOutput("rst_char_valid", {31'b0, eng_char_valid}, 32'h0);
    checkOutput("rst_irq", {31'b0, irq}, 32'h0);
    checkOutput("rst_rotor_sel", {18'b0, cfg_rotor_sel}, 32'h0);
    #20 apb_aresn = 1'b1;
    idle(2);
    busRead("rst_status", 5'h0C, 32'h0000_0008, 1'b0);

    // Rotor registers
    busWrite("wr_sel_1234", 5'h04, 32'h0000_1234, 1'b0);
    busRead("rd_sel_1234", 5'h04, 32'h0000_1234, 1'b0);
    busRead("rd_sel_byteoff", 5'h05, 32'h0000_1234, 1'b0);
    checkOutput("cfg_rotor_sel", {18'b0, cfg_rotor_sel}, 32'h0000_1234);
    busWrite("wr_sel_ffff", 5'h04, 32'h0000_FFFF, 1'b0);
    busRead("rd_sel_masked", 5'h04, 32'h0000_3777, 1'b0);
    busWrite("wr_pos_ones", 5'h08, 32'hFFFF_FFFF, 1'b0);
    busRead("rd_pos_masked", 5'h08, 32'h001F_1F1F, 1'b0);
    busWrite("wr_pos_010203", 5'h08, 32'h0001_0203, 1'b0);
    busRead("rd_pos_010203", 5'h08, 32'h0001_0203, 1'b0);

    // FIFO fill, overflow, drain
    busWrite("push_3", 5'h10, 32'd3, 1'b0);
    busWrite("push_7", 5'h10, 32'd7, 1'b0);
    busWrite("push_25", 5'h10, 32'd25, 1'b0);
    busWrite("push_0", 5'h10, 32'd0, 1'b0);
    busRead("st_full", 5'h0C, 32'h0000_0404, 1'b0);
    busWrite("push_over", 5'h10, 32'd9, 1'b1);
    busRead("st_overflow", 5'h0C, 32'h0000_0414, 1'b0);
    busWrite("push_26", 5'h10, 32'd26, 1'b1);
    popChar("pop_3", 5'd3);
    popChar("pop_7", 5'd7);
    popChar("pop_25", 5'd25);
    popChar("pop_0", 5'd0);
    busRead("st_drained", 5'h0C, 32'h0000_0018, 1'b0);
    busWrite("w1c_ovf", 5'h0C, 32'h0000_0010, 1'b0);
    busRead("st_ovf_clr", 5'h0C, 32'h0000_0008, 1'b0);

    // Push and pop together while full
    busWrite("push_1", 5'h10, 32'd1, 1'b0);
    busWrite("push_2", 5'h10, 32'd2, 1'b0);
    busWrite("push_3b", 5'h10, 32'd3, 1'b0);
    busWrite("push_4", 5'h10, 32'd4, 1'b0);
    charQ.push_back('{"pop_1_sim", 5'd1});
    applyStimulus("push_5_sim", 1'b1, 5'h10, 32'd5, 32'h0, 1'b0, 1'b1, 1'b0);
    busRead("st_full_sim", 5'h0C, 32'h0000_0404, 1'b0);
    popChar("pop_2", 5'd2);
    popChar("pop_3b", 5'd3);
    popChar("pop_4", 5'd4);
    popChar("pop_5", 5'd5);
    busRead("st_empty2", 5'h0C, 32'h0000_0008, 1'b0);

    // Other offsets
    busRead("rd_data_in", 5'h10, 32'h0, 1'b0);
    busRead("rd_ctrl", 5'h00, 32'h0, 1'b0);
    busRead("rd_unmapped_1c", 5'h1C, 32'h0, 1'b1);
    busRead("rd_unmapped_18", 5'h18, 32'h0, 1'b1);
`ifdef ENIGMA_REGBANK_IRQ_EN
    busRead("rd_irq_mask", 5'h14, 32'h0, 1'b0);
`else
    busRead("rd_irq_unmapped", 5'h14, 32'h0, 1'b1);
`endif

    // Busy engine blocks configuration and start
    eng_busy = 1'b1;
    busWrite("wr_pos_busy", 5'h08, 32'h0001_0203 ^ 32'h000B_0B0B, 1'b1);
    busRead("rd_pos_busy", 5'h08, 32'h0001_0203, 1'b0);
    busRead("st_busy", 5'h0C, 32'h0000_0009, 1'b0);
    busWrite("start_busy", 5'h00, 32'h1, 1'b1);
    idle(3);
    checkOutput("start_count_busy", startCount, 0);
    eng_busy = 1'b0;
    busWrite("start_idle", 5'h00, 32'h1, 1'b0);
    idle(3);
    checkOutput("start_count_idle", startCount, 1);

    // FIFO clear
    busWrite("push_6", 5'h10, 32'd6, 1'b0);
    busWrite("push_7b", 5'h10, 32'd7, 1'b0);
    busWrite("push_8", 5'h10, 32'd8, 1'b0);
    busRead("st_level3", 5'h0C, 32'h0000_0300, 1'b0);
    busWrite("fifo_clr", 5'h00, 32'h2, 1'b0);
    busRead("st_cleared", 5'h0C, 32'h0000_0008, 1'b0);
    checkOutput("start_count_clr", startCount, 1);

    // Sticky done
    pulseDone();
    busRead("st_done", 5'h0C, 32'h0000_000A, 1'b0);
    busWrite("w1c_done", 5'h0C, 32'h0000_0002, 1'b0);
    busRead("st_done_clr", 5'h0C, 32'h0000_0008, 1'b0);
    pulseDone();
    applyStimulus("w1c_with_done", 1'b1, 5'h0C, 32'h2, 32'h0, 1'b0, 1'b0, 1'b1);
    busRead("st_done_wins", 5'h0C, 32'h0000_000A, 1'b0);

`ifdef ENIGMA_REGBANK_IRQ_EN
    busWrite("wr_irq_mask", 5'h14, 32'h1, 1'b0);
    idle(1);
    checkOutput("irq_done", {31'b0, irq}, 32'h1);
    busRead("rd_irq_mask1", 5'h14, 32'h1, 1'b0);
    busWrite("w1c_done_irq", 5'h0C, 32'h2, 1'b0);
    idle(1);
    checkOutput("irq_cleared", {31'b0, irq}, 32'h0);
`else
    checkOutput("irq_tied", {31'b0, irq}, 32'h0);
    busWrite("w1c_done2", 5'h0C, 32'h2, 1'b0);
`endif
    busRead("st_done_clr2", 5'h0C, 32'h0000_0008, 1'b0);

    // Reset with letters in the FIFO
    busWrite("push_10", 5'h10, 32'd10, 1'b0);
    busWrite("push_11", 5'h10, 32'd11, 1'b0);
    busWrite("push_12", 5'h10, 32'd12, 1'b0);
    checkOutput("char_valid_pre", {31'b0, eng_char_valid}, 32'h1);
    #2 apb_aresn = 1'b0;
    #1;
    checkOutput("rst2_char_valid", {31'b0, eng_char_valid}, 32'h0);
    checkOutput("rst2_rotor_pos", {11'b0, cfg_rotor_pos}, 32'h0);
    idle(2);
    #2 apb_aresn = 1'b1;
    idle(2);
    busRead("st_after_rst", 5'h0C, 32'h0000_0008, 1'b0);
    busRead("sel_after_rst", 5'h04, 32'h0, 1'b0);

    idle(3);
    checkOutput("bus_queue_drained", busQ.size(), 0);
    checkOutput("char_queue_drained", charQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/enigma_regbank.md
ENIGMA_REGBANK -- requirements
Module: enigma_regbank

Interface
REQ-001 Parameter DATA_WIDTH, default 32: forwarded bus data width.
REQ-002 Parameter ADDR_WIDTH, default 5: forwarded byte address width; word index is faddr[4:2], faddr[1:0] ignored.
REQ-003 Parameter FIFO_DEPTH, default 4: character FIFO depth; power of two, at least 2.
REQ-004 apb_clock  in  1  sole clock, all state on rising edge.
REQ-005 apb_aresn  in  1  reset, asynchronous assert, active-low.
REQ-006 fwrite  in  1  forwarded access direction, 1 = write.
REQ-007 fenable  in  1  forwarded access phase; a transfer commits only while high.
REQ-008 faddr  in  ADDR_WIDTH  forwarded byte address.
REQ-009 fwdata  in  DATA_WIDTH  forwarded write data.
REQ-010 frdata  out  DATA_WIDTH  read data, combinational.
REQ-011 fslverror  out  1  access error, combinational, valid while fenable=1.
REQ-012 eng_start  out  1  one-cycle start pulse to the cipher engine.
REQ-013 cfg_rotor_sel  out  14  ROTOR_SEL register contents.
REQ-014 cfg_rotor_pos  out  21  ROTOR_POS register contents.
REQ-015 eng_busy  in  1  engine is processing.
REQ-016 eng_done  in  1  one-cycle completion pulse from the engine.
REQ-017 eng_char_valid  out  1  FIFO not empty.
REQ-018 eng_char  out  5  FIFO head letter, values 0-25.
REQ-019 eng_char_ready  in  1  engine pops the head when valid and ready are both high.
REQ-020 irq  out  1  level interrupt.

Function
REQ-021 Register map (byte offset): 0x00 CTRL, 0x04 ROTOR_SEL, 0x08 ROTOR_POS, 0x0C STATUS, 0x10 DATA_IN, 0x14 IRQ_MASK; every other offset is unmapped.
REQ-022 A write commits on the rising edge where fenable=1 and fwrite=1; each access phase commits exactly once.
REQ-023 While fenable=1 and fwrite=0, frdata shall return the addressed register; at all other times frdata shall be 0.
REQ-024 CTRL write sets bit0 START (pulses eng_start for one cycle the following cycle) and bit1 FIFO_CLR (empties the FIFO); both bits are self-clearing and always read 0.
REQ-025 ROTOR_SEL is read/write: [2:0] left, [6:4] middle, [10:8] right, [13:12] reflector. ROTOR_POS is read/write: [4:0], [12:8], [20:16]. Unused bits read 0.
REQ-026 STATUS fields: [0] busy (RO, mirrors eng_busy); [1] done (sticky, write-1-to-clear); [2] full (RO); [3] empty (RO); [4] overflow (sticky, write-1-to-clear); [10:8] FIFO level (RO).
REQ-027 DATA_IN is write-only; fwdata[4:0] is pushed into the FIFO; a read returns 0 without error.
REQ-028 fslverror=1 for: unmapped offset; write to ROTOR_SEL, ROTOR_POS or CTRL.START while eng_busy=1 (write ignored); DATA_IN push with fwdata[4:0]>25 (dropped); DATA_IN push while full with no pop in the same cycle (dropped, overflow set).
REQ-029 On a simultaneous push and pop while full, the pop completes first and the push is accepted; the level is unchanged.
REQ-030 On a simultaneous FIFO_CLR and push, the clear wins: the push is dropped with no error and overflow is unchanged.
REQ-031 On a simultaneous eng_done and a W1C of done, the set wins; the same rule applies to overflow.
REQ-032 The FIFO read and write pointers wrap modulo FIFO_DEPTH; the level counter is log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-033 While apb_aresn=0: all registers, FIFO pointers, level and sticky bits are 0; empty=1; eng_start=0; eng_char_valid=0; irq=0; frdata=0. A reset asserted mid-access discards the access.

Configuration
REQ-034 With ENIGMA_REGBANK_IRQ_EN defined: IRQ_MASK is read/write ([0] done, [1] overflow) and irq = |(mask & {overflow, done}). Without the macro: irq is tied to 0 and 0x14 is unmapped (error).

Structure
REQ-035 Package enigma_regbank_pkg holds the register offsets, STATUS/ROTOR field positions, the letter-maximum constant 25, and the default FIFO depth.
REQ-036 The FIFO is a separate sub-module, enigma_char_fifo, with push/pop/clear inputs and full/empty/level outputs.

Verification
REQ-037 Write ROTOR_SEL=0x1234 then read it back -> read data 0x1234, fslverror=0.
REQ-038 Push letters 3, 7, 25, 0 -> full=1, level=4; a 5th push -> fslverror=1, overflow=1; pops return 3, 7, 25, 0 and then empty=1.
REQ-039 With eng_busy=1, write ROTOR_POS=0x010203 -> fslverror=1 and ROTOR_POS is unchanged; write CTRL=1 -> no eng_start pulse.
REQ-040 Pulse eng_done, then write STATUS=0x2 -> done clears; with eng_done in the same cycle as the W1C -> done stays 1.
REQ-041 Read offset 0x1C -> fslverror=1, frdata=0; assert apb_aresn=0 after 3 pushes -> level=0, empty=1.
REQ-042 With ENIGMA_REGBANK_IRQ_EN defined, IRQ_MASK=1 and eng_done pulse -> irq=1 until done is cleared.
